pe_sequencer: RTL and testbench
===============================

# pe_sequencer

Control sequencer that drives one `Processing_Element` (PE) through a complete dot-product job. It accepts two operand vectors from a valid/ready stream and issues the PE's control strobes: clear, write A, write B and MAC. It then captures the PE result and returns it on a valid/ready result port. It sits between the array controller / data fetch logic and each PE, replacing hand-sequenced control.

## Interface
- `N`, 16, PE vector depth; must match the PE's `N`.
- `MAC_LAT`, 1, cycles from the last `MAC_CTRL` cycle until the PE `DATAOUT` is valid (range 1–4).
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: reset, synchronous and active-high.
- `START` in 1: begin a job; sampled only in IDLE.
- `LEN` in $clog2(N)+1: vector length, latched on accepted `START`.
- `IN_VALID` in 1 / `IN_READY` out 1 / `IN_DATA` in 32: operand stream; A words first, then B words.
- `DATAIN` out 32: to PE; equals `IN_DATA`.
- `WRITE_MAT`, `MAT_MUX`, `RST_ADD`, `RST_ACC`, `RST_PC`, `INC_PC`, `MAC_CTRL` out 1 each: PE control strobes.
- `PE_DATAOUT` in 32: PE `DATAOUT`.
- `RES_VALID` out 1 / `RES_READY` in 1 / `RES_DATA` out 32: result port.
- `BUSY` out 1: high in every state except IDLE.

## Operation
- States are IDLE, CLR, LOAD_A, LOAD_B, MAC, DRAIN, RESULT.
- IDLE → CLR when `START`=1. `LEN` is latched; `LEN`>N is clamped to N.
- CLR (1 cycle): `RST_PC`=`RST_ADD`=`RST_ACC`=1. Next state is LOAD_A, or RESULT with `RES_DATA`=0 when latched `LEN`=0.
- LOAD_A: `IN_READY`=1 and `MAT_MUX`=0.
  - `WRITE_MAT`=`IN_VALID` (a beat is accepted when `IN_VALID`&&`IN_READY`).
  - On the LEN-th accepted beat, `RST_ADD`=1 in the same cycle, and the next state is LOAD_B.
- LOAD_B: identical to LOAD_A with `MAT_MUX`=1. The last beat leads to MAC.
- MAC: `INC_PC`=`MAC_CTRL`=1 for exactly LEN cycles, then DRAIN.
- DRAIN: all strobes 0 for `MAC_LAT` cycles. On the last DRAIN edge, `RES_DATA` ← `PE_DATAOUT`. Next state is RESULT.
- RESULT: `RES_VALID`=1 and `RES_DATA` is held stable. On `RES_VALID`&&`RES_READY` → IDLE.
- `START` outside IDLE is ignored.
- `IN_VALID` outside LOAD_A/LOAD_B is ignored; `IN_READY`=0 in those states.
- `IN_VALID` low stalls the load. The beat count is unchanged and no strobe is asserted.
- All control outputs are decoded combinationally from the registered state and counter, plus `IN_VALID` (for `WRITE_MAT`/`RST_ADD` in the LOAD states).
  - No combinational path exists from `RES_READY` or `PE_DATAOUT` to any output.
- `RST` in any state: next cycle is IDLE, the counter is 0, and `RES_DATA`=0. The PE is re-cleared by the next job's CLR.

## Timing
- Reset values: every output is 0, including `IN_READY`, `RES_VALID`, `RES_DATA` and `BUSY`.
- With no stalls, counting the edge that samples `START` as edge 0:
  - CLR occupies cycle 1.
  - LOAD_A occupies the LEN cycles from edge 1.
  - LOAD_B occupies the next LEN cycles.
  - MAC occupies the next LEN cycles.
  - `RES_VALID` rises after edge 3·LEN+`MAC_LAT`+1.
- A result accepted on edge k allows `START` to be sampled on edge k+1. The back-to-back job gap is 1 IDLE cycle.
- Each input stall cycle delays `RES_VALID` by exactly one cycle.
- The internal beat/MAC counter is $clog2(N)+1 bits wide. It compares to the clamped LEN, never wraps, and is reset to 0 on each state entry.

## Structure
- Shared package `pe_seq_pkg`:
  - state enum `pe_seq_state_t`;
  - `PE_WORD_W`=32;
  - the `MAC_LAT` default.
- Single module, no sub-module. The counter and FSM are small enough to sit inline.
- The bench instantiates `pe_sequencer` + `Processing_Element` (N=16) together as the reference path.

## Test plan
- LEN=2, A={14,15}, B={13,12}, no stalls, `RES_READY`=1:
  - `RES_DATA`=362, with `RES_VALID` at edge 8 (`MAC_LAT`=1).
  - `INC_PC`/`MAC_CTRL` high for exactly 2 cycles.
  - `RST_ADD` pulses on beats 2 and 4.
- LEN=4 with `IN_VALID` dropped for 3 cycles during LOAD_B:
  - no `WRITE_MAT` during the stall;
  - result is still the correct dot product;
  - `RES_VALID` is delayed by exactly 3 cycles.
- LEN=0: CLR then RESULT with `RES_DATA`=0, `IN_READY` never high, `MAC_CTRL` never high.
- LEN=17 (N=16): clamped; exactly 16 A beats and 16 B beats are accepted, and 16 MAC cycles occur.
- `RES_READY` held low 5 cycles in RESULT:
  - `RES_DATA` stable;
  - `START` pulses are ignored;
  - the next job starts only after the handshake.
- `RST` asserted mid-LOAD_B:
  - next cycle all outputs are 0 and the state is IDLE;
  - a following LEN=2 job yields 362 again.

Source files
------------

// File: rtl/pe_seq_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | pe_seq_pkg                                                           |
// | Shared types and constants for the PE control sequencer.             |
// |   pe_seq_state_t     : sequencer state encoding                      |
// |   PE_WORD_W          : PE datapath word width                        |
// |   PE_MAC_LAT_DEFAULT : default PE MAC-to-DATAOUT latency              |
// | Revision: 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
package pe_seq_pkg;

  localparam int PE_WORD_W          = 32;
  localparam int PE_MAC_LAT_DEFAULT = 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_LOAD_A = 3'd2,
    S_LOAD_B = 3'd3,
    S_MAC    = 3'd4,
    S_DRAIN  = 3'd5,
    S_RESULT = 3'd6
  } pe_seq_state_t;

endpackage
`default_nettype wire

// File: rtl/pe_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | pe_sequencer                                                         |
// | Drives one Processing_Element through a full dot-product job: clear, |
// | load A, load B, MAC for LEN cycles, wait for the PE latency, then    |
// | return the captured PE result on a valid/ready port.                 |
// | Ports:                                                               |
// |   CLK, RST                  : clock, sync active-high reset          |
// |   START, LEN                : job request (sampled in IDLE only)     |
// |   IN_VALID/IN_READY/IN_DATA : operand stream, A words then B words   |
// |   DATAIN                    : operand word to the PE                 |
// |   WRITE_MAT .. MAC_CTRL     : PE control strobes                     |
// |   PE_DATAOUT                : PE accumulator output                  |
// |   RES_VALID/RES_READY/RES_DATA : result port                         |
// |   BUSY                      : high whenever not IDLE                 |
// | Revision: 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module pe_sequencer
  import pe_seq_pkg::*;
#(
  parameter  int N       = 16,
  parameter  int MAC_LAT = PE_MAC_LAT_DEFAULT,
  localparam int LW      = $clog2(N) + 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [LW-1:0]        LEN,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [PE_WORD_W-1:0] IN_DATA,
  output logic [PE_WORD_W-1:0] DATAIN,
  output logic                 WRITE_MAT,
  output logic                 MAT_MUX,
  output logic                 RST_ADD,
  output logic                 RST_ACC,
  output logic                 RST_PC,
  output logic                 INC_PC,
  output logic                 MAC_CTRL,
  input  logic [PE_WORD_W-1:0] PE_DATAOUT,
  output logic                 RES_VALID,
  input  logic                 RES_READY,
  output logic [PE_WORD_W-1:0] RES_DATA,
  output logic                 BUSY
);

  localparam logic [LW-1:0] c_n          = LW'(N);
  localparam logic [LW-1:0] c_drain_last = LW'(MAC_LAT - 1);

  pe_seq_state_t        state_q, state_d;
  logic [LW-1:0]        cnt_q, cnt_d;
  logic [LW-1:0]        len_q, len_d;
  logic [PE_WORD_W-1:0] res_q, res_d;

  logic [LW-1:0]        len_clamped;
  logic                 cnt_last;

  assign len_clamped = (LEN > c_n) ? c_n : LEN;
  // Only consulted in LOAD/MAC states, where len_q is never zero.
  assign cnt_last    = (cnt_q == (len_q - LW'(1)));

  assign DATAIN   = IN_DATA;
  assign RES_DATA = res_q;
  assign BUSY     = (state_q != S_IDLE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    res_d     = res_q;
    IN_READY  = 1'b0;
    WRITE_MAT = 1'b0;
    MAT_MUX   = 1'b0;
    RST_ADD   = 1'b0;
    RST_ACC   = 1'b0;
    RST_PC    = 1'b0;
    INC_PC    = 1'b0;
    MAC_CTRL  = 1'b0;
    RES_VALID = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          len_d   = len_clamped;
          cnt_d   = '0;
          state_d = S_CLR;
        end
      end

      S_CLR: begin
        RST_PC  = 1'b1;
        RST_ADD = 1'b1;
        RST_ACC = 1'b1;
        cnt_d   = '0;
        if (len_q == '0) begin
          // Empty job: skip the PE entirely and report a zero result.
          res_d   = '0;
          state_d = S_RESULT;
        end else begin
          state_d = S_LOAD_A;
        end
      end

      S_LOAD_A, S_LOAD_B: begin
        IN_READY  = 1'b1;
        MAT_MUX   = (state_q == S_LOAD_B);
        WRITE_MAT = IN_VALID;
        if (IN_VALID) begin
          if (cnt_last) begin
            // Rewind the PE write address alongside the final beat so the
            // next operand block starts at address 0.
            RST_ADD = 1'b1;
            cnt_d   = '0;
            state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_MAC;
          end else begin
            cnt_d = cnt_q + LW'(1);
          end
        end
      end

      S_MAC: begin
        INC_PC   = 1'b1;
        MAC_CTRL = 1'b1;
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + LW'(1);
        end
      end

      S_DRAIN: begin
        if (cnt_q == c_drain_last) begin
          res_d   = PE_DATAOUT;
          cnt_d   = '0;
          state_d = S_RESULT;
        end else begin
          cnt_d = cnt_q + LW'(1);
        end
      end

      S_RESULT: begin
        RES_VALID = 1'b1;
        if (RES_READY) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      res_q   <= res_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pe_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_pe_sequencer                                                      |
// | Self-checking bench for pe_sequencer with a behavioural PE attached. |
// | Revision: 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module tb_pe_sequencer;
  import pe_seq_pkg::*;

  localparam int N  = 16;
  localparam int ML = 1;
  localparam int LW = $clog2(N) + 1;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_ready, res_ready, res_valid, busy;
  logic [LW-1:0] len;
  logic [31:0] in_data, datain, pe_dataout, res_data;
  logic        write_mat, mat_mux, rst_add, rst_acc, rst_pc, inc_pc, mac_ctrl;

  always #5 clk = ~clk;

  pe_sequencer #(.N(N), .MAC_LAT(ML)) dut (
    .CLK(clk), .RST(rst), .START(start), .LEN(len),
    .IN_VALID(in_valid), .IN_READY(in_ready), .IN_DATA(in_data),
    .DATAIN(datain), .WRITE_MAT(write_mat), .MAT_MUX(mat_mux),
    .RST_ADD(rst_add), .RST_ACC(rst_acc), .RST_PC(rst_pc),
    .INC_PC(inc_pc), .MAC_CTRL(mac_ctrl), .PE_DATAOUT(pe_dataout),
    .RES_VALID(res_valid), .RES_READY(res_ready), .RES_DATA(res_data),
    .BUSY(busy)
  );

  // Behavioural Processing_Element: two operand memories, a write address,
  // a MAC program counter and an accumulator visible after ML cycles.
  logic [31:0]          pe_ma [N];
  logic [31:0]          pe_mb [N];
  logic [$clog2(N)-1:0] pe_addr = '0;
  logic [$clog2(N)-1:0] pe_pc   = '0;
  logic [31:0]          pe_acc  = '0;
  logic [31:0]          pe_pipe [4];

  always @(posedge clk) begin
    if (write_mat) begin
      if (mat_mux) pe_mb[pe_addr] <= datain;
      else         pe_ma[pe_addr] <= datain;
    end
    if (rst_add)        pe_addr <= '0;
    else if (write_mat) pe_addr <= pe_addr + 1'b1;
    if (rst_acc)       pe_acc <= '0;
    else if (mac_ctrl) pe_acc <= pe_acc + pe_ma[pe_pc] * pe_mb[pe_pc];
    if (rst_pc)      pe_pc <= '0;
    else if (inc_pc) pe_pc <= pe_pc + 1'b1;
    pe_pipe[0] <= pe_acc;
    for (int i = 1; i < 4; i++) pe_pipe[i] <= pe_pipe[i-1];
  end

  always_comb begin
    pe_dataout = pe_acc;
    if (ML >= 2) pe_dataout = pe_pipe[(ML >= 2) ? ML - 2 : 0];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  logic [31:0] opa [32];
  logic [31:0] opb [32];
  logic [31:0] last_res;

  function automatic logic [31:0] ref_dot(input int l);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < l; i++) s = s + opa[i] * opb[i];
    return s;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 32; i++) begin
      opa[i] = $urandom;
      opb[i] = $urandom;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ctrl"}, {in_ready, write_mat, mat_mux, rst_add, rst_acc, rst_pc,
                              inc_pc, mac_ctrl, res_valid, busy}, 0);
    check_eq({tag, "_res"}, res_data, 0);
    check_eq({tag, "_datain"}, datain, 0);
  endtask

  // One complete job. Called at a point after the negedge; START is sampled
  // on the next rising edge (edge 0).
  task automatic run_job(input int len_in, input int stall_at, input int stall_len,
                         input bit rnd_stall, input int ready_delay, input int abort_beat);
    int L, k, beats, stalls, forced_left, wa, wb, macs, rdy_cyc, waited, n_radd, exp_edge;
    bit seen, done;
    logic [31:0] exp_res, held;
    L = (len_in > N) ? N : len_in;
    exp_res = ref_dot(L);
    k = 0; beats = 0; stalls = 0; forced_left = stall_len; wa = 0; wb = 0; macs = 0;
    rdy_cyc = 0; waited = 0; n_radd = 0; seen = 0; done = 0; held = '0;
    start = 1'b1;
    len   = LW'(len_in);
    @(posedge clk); #1;
    start = 1'b0;
    while (!done && k < 500) begin
      if (abort_beat > 0 && beats == abort_beat) begin
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b1; in_data = '0; start = 1'b0;
        @(negedge clk);
        check_all_zero("mid_reset");
        in_valid = 1'b0;
        return;
      end
      if (beats >= 1 && beats < 2*L && beats == stall_at && forced_left > 0) begin
        in_valid = 1'b0; forced_left--; stalls++;
      end else if (beats >= 1 && beats < 2*L && rnd_stall && $urandom_range(3) == 0) begin
        in_valid = 1'b0; stalls++;
      end else if (beats < 2*L) begin
        in_valid = 1'b1;
        in_data  = (beats < L) ? opa[beats] : opb[beats-L];
      end else begin
        in_valid = 1'($urandom_range(1));
        in_data  = $urandom;
      end
      res_ready = (waited >= ready_delay);
      start     = (seen && !res_ready) ? 1'($urandom_range(1)) : 1'b0;
      @(negedge clk);
      check_eq("busy", busy, 1);
      check_eq("wr_vs_hs", write_mat, in_valid && in_ready);
      check_eq("inc_vs_mac", inc_pc, mac_ctrl);
      if (write_mat) begin
        if (mat_mux) wb++;
        else         wa++;
      end
      if (in_ready) rdy_cyc++;
      if (mac_ctrl) macs++;
      if (in_valid && in_ready) beats++;
      if (rst_add && in_ready) begin
        n_radd++;
        check_eq("rst_add_beat", (beats == L) || (beats == 2*L), 1);
      end
      if (res_valid) begin
        if (!seen) begin
          seen = 1'b1;
          held = res_data;
          exp_edge = (L == 0) ? 1 : 3*L + ML + 1 + stalls;
          check_eq("res_edge", k, exp_edge);
          check_eq("res_data", res_data, exp_res);
        end else begin
          check_eq("res_stable", res_data, held);
        end
        if (res_ready) done = 1'b1;
        else           waited++;
      end
      @(posedge clk); #1;
      k++;
    end
    check_eq("job_done", done, 1);
    start = 1'b0; in_valid = 1'b0; in_data = '0;
    @(negedge clk);
    check_eq("idle_valid", res_valid, 0);
    check_eq("idle_busy", busy, 0);
    check_eq("a_beats", wa, L);
    check_eq("b_beats", wb, L);
    check_eq("mac_cycles", macs, L);
    check_eq("ready_cycles", rdy_cyc, 2*L + stalls);
    check_eq("rst_add_pulses", n_radd, (L > 0) ? 2 : 0);
    last_res = held;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");

    // Directed LEN=2 job.
    opa[0] = 14; opa[1] = 15; opb[0] = 13; opb[1] = 12;
    run_job(2, 0, 0, 1'b0, 0, 0);
    check_eq("dot_362", last_res, 362);

    // LEN=4 with a 3-cycle input stall inside LOAD_B.
    fill_random();
    run_job(4, 5, 3, 1'b0, 0, 0);

    // Empty job.
    run_job(0, 0, 0, 1'b0, 0, 0);

    // Over-long job, clamped to N.
    fill_random();
    run_job(17, 0, 0, 1'b0, 0, 0);

    // Result held for 5 cycles with stray START pulses.
    fill_random();
    run_job(3, 0, 0, 1'b0, 5, 0);

    // Reset during LOAD_B, then the directed job again.
    fill_random();
    run_job(4, 0, 0, 1'b0, 0, 6);
    opa[0] = 14; opa[1] = 15; opb[0] = 13; opb[1] = 12;
    run_job(2, 0, 0, 1'b0, 0, 0);
    check_eq("dot_362_again", last_res, 362);

    // Randomized jobs with random stalls and result back-pressure.
    for (int j = 0; j < 12; j++) begin
      fill_random();
      run_job(int'($urandom_range(0, 20)), 0, 0, 1'b1, int'($urandom_range(0, 3)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
